// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared widths and FSM state encoding for the sequential 64-bit adder
package add_pkg;

  localparam int FULL_W = 64;
  localparam int HALF_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/full_adder_32bit.sv
// rtl/full_adder_32bit.sv - combinational 32-bit adder with carry-out and signed overflow
module full_adder_32bit
  import add_pkg::*;
(
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  input  logic              cin,
  output logic [HALF_W-1:0] sum,
  output logic              cout,
  output logic              overflow
);

  logic [HALF_W:0] total;
  logic            carry_into_msb;

  assign total = {1'b0, a} + {1'b0, b} + {{HALF_W{1'b0}}, cin};

  // Carry into the MSB recovered from the MSB sum bit; cin is already folded in.
  assign carry_into_msb = a[HALF_W-1] ^ b[HALF_W-1] ^ total[HALF_W-1];

  assign sum      = total[HALF_W-1:0];
  assign cout     = total[HALF_W];
  assign overflow = carry_into_msb ^ total[HALF_W];

endmodule

// File: rtl/add64_seq.sv
// rtl/add64_seq.sv - 64-bit add done as two passes through one 32-bit adder, low half first
module add64_seq
  import add_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FULL_W-1:0] a,
  input  logic [FULL_W-1:0] b,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FULL_W-1:0] sum,
  output logic              cout,
  output logic              overflow,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [FULL_W-1:0]   a_q, a_d;
  logic [FULL_W-1:0]   b_q, b_d;
  logic                cin_q, cin_d;
  logic [HALF_W-1:0]   sum_lo_q, sum_lo_d;
  logic                carry_q, carry_d;
  logic [FULL_W-1:0]   sum_q, sum_d;
  logic                cout_q, cout_d;
  logic                ovf_q, ovf_d;

  logic                accept;
  logic                hi_pass;
  logic [HALF_W-1:0]   add_a, add_b, add_sum;
  logic                add_cin, add_cout, add_ovf;

  assign hi_pass = (state_q == HIGH);
  assign add_a   = hi_pass ? a_q[FULL_W-1:HALF_W] : a_q[HALF_W-1:0];
  assign add_b   = hi_pass ? b_q[FULL_W-1:HALF_W] : b_q[HALF_W-1:0];
  assign add_cin = hi_pass ? carry_q : cin_q;

  full_adder_32bit u_adder (
    .a        (add_a),
    .b        (add_b),
    .cin      (add_cin),
    .sum      (add_sum),
    .cout     (add_cout),
    .overflow (add_ovf)
  );

  // Gated by rst so the port reads 0 for the whole reset window.
  assign in_ready  = ~rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == LOW) | (state_q == HIGH);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    sum_lo_d = sum_lo_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    if (accept) begin
      a_d   = a;
      b_d   = b;
      cin_d = cin;
    end

    case (state_q)
      IDLE: if (accept) state_d = LOW;
      LOW: begin
        sum_lo_d = add_sum;
        carry_d  = add_cout;
        state_d  = HIGH;
      end
      HIGH: begin
        sum_d   = {add_sum, sum_lo_q};
        cout_d  = add_cout;
        ovf_d   = add_ovf;
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = accept ? LOW : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      sum_lo_q <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      sum_lo_q <= sum_lo_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_add64_seq.sv
// tb/tb_add64_seq.sv - self-checking bench for add64_seq against an arithmetic reference model
module tb_add64_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;
  logic        overflow;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  add64_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: {overflow, cout, sum} from plain 65-bit arithmetic and operand/result signs.
  function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y, input logic c);
    logic [64:0] t;
    logic        ovf;
    t   = {1'b0, x} + {1'b0, y} + {64'd0, c};
    ovf = (x[63] == y[63]) && (t[63] != x[63]);
    return {ovf, t[64], t[63:0]};
  endfunction

  task automatic run_op(input logic [63:0] x, input logic [63:0] y, input logic c,
                        output int lat, output logic busy0, output logic busy1);
    a = x; b = y; cin = c; in_valid = 1'b1;
    busy1 = 1'b0;
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    busy0 = busy;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) busy1 = busy;
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_checks++; if ({sum, cout, overflow, busy} !== 67'd0)
      $display("FAIL reset_outputs got sum=%h cout=%b ovf=%b busy=%b exp all 0", sum, cout, overflow, busy);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready got=%b exp=1", in_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_directed();
    logic [63:0] ta [5];
    logic [63:0] tb [5];
    logic        tc [5];
    logic [63:0] es [5];
    logic        ec [5];
    logic        eo [5];
    int          lat;
    logic        b0, b1;
    ta = '{64'd5, 64'h0000_0000_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    tb = '{64'd10, 64'd1, 64'd1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    tc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    es = '{64'd15, 64'h0000_0001_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    ec = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    eo = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    drain();
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], tc[i], lat, b0, b1);
      n_checks++; if (lat != 2) $display("FAIL dir%0d_latency got=%0d exp=2", i, lat); else n_pass++;
      n_checks++; if (sum !== es[i]) $display("FAIL dir%0d_sum got=%h exp=%h", i, sum, es[i]); else n_pass++;
      n_checks++; if (cout !== ec[i]) $display("FAIL dir%0d_cout got=%b exp=%b", i, cout, ec[i]); else n_pass++;
      n_checks++; if (overflow !== eo[i]) $display("FAIL dir%0d_ovf got=%b exp=%b", i, overflow, eo[i]); else n_pass++;
      if (i == 0) begin
        n_checks++; if ({b0, b1} !== 2'b11) $display("FAIL dir0_busy got=%b%b exp=11", b0, b1); else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [65:0] e;
    int          lat;
    logic        b0, b1;
    drain();
    out_ready = 1'b0;
    e = model(64'h1234_5678_9ABC_DEF0, 64'hF0F0_0000_7654_3210, 1'b1);
    run_op(64'h1234_5678_9ABC_DEF0, 64'hF0F0_0000_7654_3210, 1'b1, lat, b0, b1);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_hold%0d_valid got=%b exp=1", i, out_valid); else n_pass++;
      n_checks++; if ({overflow, cout, sum} !== e)
        $display("FAIL bp_hold%0d_result got=%b/%b/%h exp=%b/%b/%h", i, overflow, cout, sum, e[65], e[64], e[63:0]);
      else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_hold%0d_in_ready got=%b exp=0", i, in_ready); else n_pass++;
      @(posedge clk); #1;
    end
    a = 64'd1; b = 64'd2; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_handoff_ready got=%b exp=1", in_ready); else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if ({out_valid, busy} !== 2'b01) $display("FAIL bp_handoff_state got v/b=%b%b exp=01", out_valid, busy); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_next_valid got=%b exp=1", out_valid); else n_pass++;
    n_checks++; if (sum !== 64'd3) $display("FAIL bp_next_sum got=%h exp=3", sum); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int   lat;
    logic b0, b1;
    drain();
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; cin = 1'b0; in_valid = 1'b1;
    #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b1) $display("FAIL rstmid_in_high got busy=%b exp=1", busy); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if ({sum, cout, overflow, out_valid, in_ready, busy} !== 69'd0)
      $display("FAIL rstmid_zero got sum=%h c=%b o=%b v=%b r=%b busy=%b exp all 0", sum, cout, overflow, out_valid, in_ready, busy);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_ready got=%b exp=1", in_ready); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_no_pulse%0d got=%b exp=0", i, out_valid); else n_pass++;
    end
    run_op(64'd3, 64'd4, 1'b0, lat, b0, b1);
    n_checks++; if (lat != 2) $display("FAIL rstmid_latency got=%0d exp=2", lat); else n_pass++;
    n_checks++; if ({overflow, cout, sum} !== {2'b00, 64'd7})
      $display("FAIL rstmid_result got=%b/%b/%h exp=0/0/7", overflow, cout, sum);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] x, y;
    logic        c;
    logic [65:0] e;
    int          lat;
    logic        b0, b1;
    drain();
    for (int i = 0; i < 30; i++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      c = 1'($urandom);
      if (i % 5 == 0) y[31:0] = ~x[31:0];
      e = model(x, y, c);
      run_op(x, y, c, lat, b0, b1);
      n_checks++; if (lat != 2 || {overflow, cout, sum} !== e)
        $display("FAIL rand%0d got lat=%0d %b/%b/%h exp lat=2 %b/%b/%h", i, lat, overflow, cout, sum, e[65], e[64], e[63:0]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [65:0] q[$];
    logic [65:0] e;
    int          sent, got, cyc, last;
    logic        acc;
    drain();
    sent = 0; got = 0; cyc = 0; last = -1;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom);
    in_valid = 1'b1;
    #1;
    while (got < 8 && cyc < 60) begin
      if (out_valid) begin
        e = (q.size() > 0) ? q.pop_front() : 66'd0;
        n_checks++; if ({overflow, cout, sum} !== e)
          $display("FAIL b2b%0d_result got=%b/%b/%h exp=%b/%b/%h", got, overflow, cout, sum, e[65], e[64], e[63:0]);
        else n_pass++;
        if (last >= 0) begin
          n_checks++; if (cyc - last != 3) $display("FAIL b2b%0d_spacing got=%0d exp=3", got, cyc - last); else n_pass++;
        end
        last = cyc;
        got++;
      end
      acc = in_valid && in_ready;
      if (acc) q.push_back(model(a, b, cin));
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        if (sent < 8) begin
          a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom);
        end else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_checks++; if (got != 8) $display("FAIL b2b_count got=%0d exp=8", got); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
